demux_1to2_stream: RTL and testbench
====================================

// Module: demux_1to2_stream
// PURPOSE
//  Registered 1-to-2 stream demultiplexer with valid/ready handshake.
//  Sits downstream of a producer and replaces the combinational 1-to-2 demux
//    where the two consumers can stall independently.
//  Each input beat goes to output 0 or 1 according to in_sel.
//  Each output has a one-entry holding register, so a stalled consumer never
//    blocks the other.
// PARAMETERS
//  width   8    data width of in_data, o0_data, o1_data
//  CNT_W   16   width of the delivered-beat counters (DEMUX_CNT_EN only)
// PORTS
//  clk        in   1       single clock, rising edge
//  rst_n      in   1       asynchronous, active-low reset
//  in_valid   in   1       input beat valid
//  in_ready   out  1       input beat accepted this cycle when in_valid&in_ready
//  in_sel     in   1       destination: 0 -> o0, 1 -> o1
//  in_data    in   width   input payload
//  o0_valid   out  1       o0 holding register full
//  o0_ready   in   1       o0 consumer ready
//  o0_data    out  width   o0 payload
//  o1_valid   out  1       o1 holding register full
//  o1_ready   in   1       o1 consumer ready
//  o1_data    out  width   o1 payload
//  o0_cnt     out  CNT_W   beats delivered on o0 (DEMUX_CNT_EN only)
//  o1_cnt     out  CNT_W   beats delivered on o1 (DEMUX_CNT_EN only)
// BEHAVIOUR
//  Reset (async, rst_n=0): all full flags=0, all data regs=0, counters=0.
//    Consequence: oX_valid=0 immediately.
//  Per slot X, two states: EMPTY (full=0) and FULL (full=1).
//  drain_X = oX_valid & oX_ready.
//  in_ready = ~full[in_sel] | drain[in_sel].
//    Combinational from in_sel, the slot state and oX_ready.
//  accept = in_valid & in_ready.
//    Loads in_data into slot[in_sel]; that slot is FULL on the next edge.
//  Latency: 1 cycle, from accept edge to oX_valid=1 with the payload.
//  Transitions:
//    EMPTY -> FULL on accept.
//    FULL  -> EMPTY on drain without accept.
//    FULL stays FULL on drain & accept in the same cycle (new data replaces old).
//    FULL stays FULL while oX_ready=0.
//  Unselected slot: unaffected by the input; drains independently.
//  oX_data holds stable while oX_valid=1 & oX_ready=0.
//  oX_data keeps its last value while EMPTY; consumers must qualify it with oX_valid.
//  in_data and in_sel are ignored when in_valid=0.
//  Reset mid-operation: held beats are discarded; no beat is delivered after reset.
//  Throughput: 1 beat/cycle per output when the consumer holds ready=1.
// CONFIGURATION
//  `DEMUX_CNT_EN defined:
//    o0_cnt/o1_cnt ports exist.
//    oX_cnt increments by 1 on each drain_X and wraps from 2^CNT_W-1 to 0.
//    Reset value 0.
//  `DEMUX_CNT_EN undefined:
//    counter ports and logic are absent.
//    Datapath and handshake are identical in both builds.
// STRUCTURE
//  Shared package demux_pkg:
//    localparams SEL_O0=1'b0, SEL_O1=1'b1
//    default DEMUX_WIDTH=8, default DEMUX_CNT_W=16
//  Sub-module demux_out_slot (params width, CNT_W):
//    one-entry register with full flag, load/drain logic and optional counter.
//    Instantiated twice; the top holds only in_sel decode and in_ready mux.
// TESTING
//  Bench uses width=8.
//  1. Reset:
//     rst_n=0 -> o0_valid=o1_valid=0, o0_data=o1_data=8'h00, in_ready=1.
//  2. Route to o0:
//     in_data=8'hA0, in_sel=0, in_valid=1 for 1 cycle, o0_ready=1
//     -> next cycle o0_valid=1, o0_data=8'hA0, for exactly 1 cycle; o1_valid stays 0.
//  3. Backpressure on o1:
//     o1_ready=0; send 8'hB0 then 8'hB1 with in_sel=1
//     -> 8'hB0 accepted; in_ready=0 for 8'hB1; o1_data holds 8'hB0.
//     Raise o1_ready -> 8'hB0 drains and 8'hB1 is accepted in the same cycle
//     -> o1_data=8'hB1 next cycle.
//  4. Independence:
//     o1 FULL with o1_ready=0; send 8'hA1 with in_sel=0
//     -> in_ready=1; o0 delivers 8'hA1 one cycle later; o1 still holds its beat.
//  5. Async reset mid-op:
//     o0 FULL with 8'hA2, o0_ready=0; drop rst_n between clock edges
//     -> o0_valid=0 at once; after release there is no stale delivery.
//  6. DEMUX_CNT_EN build:
//     deliver 3 beats on o0 and 2 on o1 -> o0_cnt=3, o1_cnt=2.
//     With CNT_W=4, deliver 16 beats on o0 -> o0_cnt wraps to 0.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared constants and slot state type for the 1-to-2 stream demultiplexer.
// Optional delivered-beat counters are enabled with DEMUX_CNT_EN.
package demux_pkg;

   localparam logic SEL_O0 = 1'b0;
   localparam logic SEL_O1 = 1'b1;

   localparam int DEMUX_WIDTH = 8;
   localparam int DEMUX_CNT_W = 16;

   typedef enum logic {
      SLOT_EMPTY = 1'b0,
      SLOT_FULL  = 1'b1
   } slot_state_t;

endpackage

// File: rtl/demux_1to2_stream_if.sv
// Handshake bundle of the 1-to-2 demux: one input stream, two output streams.
// slave is the demux side, master is the producer/consumer side.
interface demux_1to2_stream_if
   import demux_pkg::*;
#(
   parameter int width = DEMUX_WIDTH
);

   logic             in_valid;
   logic             in_ready;
   logic             in_sel;
   logic [width-1:0] in_data;

   logic             o0_valid;
   logic             o0_ready;
   logic [width-1:0] o0_data;

   logic             o1_valid;
   logic             o1_ready;
   logic [width-1:0] o1_data;

   modport slave (
      input  in_valid, in_sel, in_data, o0_ready, o1_ready,
      output in_ready, o0_valid, o0_data, o1_valid, o1_data
   );

   modport master (
      output in_valid, in_sel, in_data, o0_ready, o1_ready,
      input  in_ready, o0_valid, o0_data, o1_valid, o1_data
   );

endinterface

// File: rtl/demux_out_slot.sv
// One-entry output holding register with full flag and load/drain handshake.
// With DEMUX_CNT_EN defined it also counts drained beats (wrapping).
module demux_out_slot
   import demux_pkg::*;
#(
   parameter int width = DEMUX_WIDTH
`ifdef DEMUX_CNT_EN
   , parameter int CNT_W = DEMUX_CNT_W
`endif
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [width-1:0] load_data,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [width-1:0] out_data,
   output logic             can_load
`ifdef DEMUX_CNT_EN
   , output logic [CNT_W-1:0] cnt
`endif
);

   slot_state_t      state_reg;
   logic [width-1:0] data_reg;
   logic             drain;

   assign drain    = (state_reg == SLOT_FULL) & out_ready;
   // A draining slot can take a new beat in the same cycle, keeping 1 beat/cycle.
   assign can_load = (state_reg == SLOT_EMPTY) | drain;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= SLOT_EMPTY;
         data_reg  <= '0;
      end else if (load) begin
         state_reg <= SLOT_FULL;
         data_reg  <= load_data;
      end else if (drain) begin
         state_reg <= SLOT_EMPTY;
      end
   end

   assign out_valid = (state_reg == SLOT_FULL);
   assign out_data  = data_reg;

`ifdef DEMUX_CNT_EN
   logic [CNT_W-1:0] cnt_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg <= '0;
      end else if (drain) begin
         cnt_reg <= cnt_reg + CNT_W'(1);
      end
   end

   assign cnt = cnt_reg;
`endif

endmodule

// File: rtl/demux_1to2_stream.sv
// Registered 1-to-2 stream demux; each output owns a one-entry slot so the
// consumers stall independently. DEMUX_CNT_EN adds o0_cnt/o1_cnt.
module demux_1to2_stream
   import demux_pkg::*;
#(
   parameter int width = DEMUX_WIDTH
`ifdef DEMUX_CNT_EN
   , parameter int CNT_W = DEMUX_CNT_W
`endif
) (
   input  logic                clk,
   input  logic                rst_n,
   demux_1to2_stream_if.slave  bus
`ifdef DEMUX_CNT_EN
   , output logic [CNT_W-1:0]  o0_cnt
   , output logic [CNT_W-1:0]  o1_cnt
`endif
);

   logic [1:0]       slot_ready;
   logic [1:0]       slot_valid;
   logic [1:0]       can_load;
   logic [1:0]       load;
   logic [width-1:0] slot_data [2];
   logic             in_ready;
`ifdef DEMUX_CNT_EN
   logic [CNT_W-1:0] slot_cnt [2];
`endif

   assign slot_ready = {bus.o1_ready, bus.o0_ready};
   assign in_ready   = can_load[bus.in_sel];

   for (genvar gi = 0; gi < 2; gi++) begin : g_slot
      localparam logic SLOT_SEL = (gi == 0) ? SEL_O0 : SEL_O1;

      assign load[gi] = bus.in_valid & in_ready & (bus.in_sel == SLOT_SEL);

      demux_out_slot #(
         .width (width)
`ifdef DEMUX_CNT_EN
         , .CNT_W (CNT_W)
`endif
      ) u_slot (
         .clk       (clk),
         .rst_n     (rst_n),
         .load      (load[gi]),
         .load_data (bus.in_data),
         .out_ready (slot_ready[gi]),
         .out_valid (slot_valid[gi]),
         .out_data  (slot_data[gi]),
         .can_load  (can_load[gi])
`ifdef DEMUX_CNT_EN
         , .cnt     (slot_cnt[gi])
`endif
      );
   end

   assign bus.in_ready = in_ready;
   assign bus.o0_valid = slot_valid[0];
   assign bus.o0_data  = slot_data[0];
   assign bus.o1_valid = slot_valid[1];
   assign bus.o1_data  = slot_data[1];

`ifdef DEMUX_CNT_EN
   assign o0_cnt = slot_cnt[0];
   assign o1_cnt = slot_cnt[1];
`endif

endmodule

// File: tb/tb_demux_1to2_stream.sv
// Bench for demux_1to2_stream: directed scenarios plus random traffic, checked
// every cycle against a queue-based model. Define DEMUX_CNT_EN to cover counters.
module tb_demux_1to2_stream;

   localparam int W     = 8;
   localparam int TB_CNT_W = 4;

   logic clk;
   logic rst_n;

   demux_1to2_stream_if #(.width(W)) bus ();

`ifdef DEMUX_CNT_EN
   logic [TB_CNT_W-1:0] o0_cnt;
   logic [TB_CNT_W-1:0] o1_cnt;
`endif

   demux_1to2_stream #(
      .width (W)
`ifdef DEMUX_CNT_EN
      , .CNT_W (TB_CNT_W)
`endif
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
`ifdef DEMUX_CNT_EN
      , .o0_cnt (o0_cnt)
      , .o1_cnt (o1_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Model: each output is a FIFO of capacity one, plus the last value loaded
   // (the output data bus keeps it while empty) and a delivered-beat count.
   logic [W-1:0] held [2][$];
   logic [W-1:0] last_val [2];
   int           delivered [2];

   function automatic logic [W-1:0] dut_data(input int x);
      return (x == 0) ? bus.o0_data : bus.o1_data;
   endfunction

   function automatic logic dut_valid(input int x);
      return (x == 0) ? bus.o0_valid : bus.o1_valid;
   endfunction

   function automatic logic cons_ready(input int x);
      return (x == 0) ? bus.o0_ready : bus.o1_ready;
   endfunction

   always @(negedge clk) begin
      if (!rst_n) begin
         for (int x = 0; x < 2; x++) begin
            held[x].delete();
            last_val[x]  = '0;
            delivered[x] = 0;
            chk($sformatf("rst_valid%0d", x), 32'(dut_valid(x)), 32'd0);
         end
      end else begin
         int  s;
         logic exp_ready;
         logic [W-1:0] popped;
         for (int x = 0; x < 2; x++) begin
            chk($sformatf("valid%0d", x), 32'(dut_valid(x)), 32'(held[x].size() != 0));
            chk($sformatf("data%0d", x), 32'(dut_data(x)), 32'(last_val[x]));
         end
`ifdef DEMUX_CNT_EN
         chk("cnt0", 32'(o0_cnt), 32'(delivered[0] % (1 << TB_CNT_W)));
         chk("cnt1", 32'(o1_cnt), 32'(delivered[1] % (1 << TB_CNT_W)));
`endif
         s = int'(bus.in_sel);
         exp_ready = (held[s].size() == 0) || cons_ready(s);
         chk("in_ready", 32'(bus.in_ready), 32'(exp_ready));
         // Advance the model across the coming rising edge.
         for (int x = 0; x < 2; x++) begin
            if (held[x].size() != 0 && cons_ready(x)) begin
               popped = held[x].pop_front();
               delivered[x]++;
               $display("t=%0t deliver o%0d data=%02h", $time, x, popped);
            end
         end
         if (bus.in_valid && exp_ready) begin
            held[s].push_back(bus.in_data);
            last_val[s] = bus.in_data;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_beats(input logic sel, input int n, input logic [W-1:0] base);
      for (int i = 0; i < n; i++) begin
         bus.in_valid = 1'b1;
         bus.in_sel   = sel;
         bus.in_data  = base + W'(i);
         tick();
      end
      bus.in_valid = 1'b0;
      tick();
   endtask

   initial begin
      rst_n        = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_sel   = 1'b0;
      bus.in_data  = '0;
      bus.o0_ready = 1'b1;
      bus.o1_ready = 1'b1;

      // Reset state
      #3;
      chk("reset_o0_valid", 32'(bus.o0_valid), 32'd0);
      chk("reset_o1_valid", 32'(bus.o1_valid), 32'd0);
      chk("reset_o0_data", 32'(bus.o0_data), 32'h00);
      chk("reset_o1_data", 32'(bus.o1_data), 32'h00);
      chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
      #19 rst_n = 1'b1;
      tick();

      // Route to o0: one-cycle latency, one-cycle pulse
      bus.in_data = 8'hA0; bus.in_sel = 1'b0; bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      #1;
      chk("route_o0_valid", 32'(bus.o0_valid), 32'd1);
      chk("route_o0_data", 32'(bus.o0_data), 32'hA0);
      chk("route_o1_valid", 32'(bus.o1_valid), 32'd0);
      tick();
      chk("route_o0_pulse", 32'(bus.o0_valid), 32'd0);

      // Backpressure on o1
      bus.o1_ready = 1'b0;
      bus.in_data = 8'hB0; bus.in_sel = 1'b1; bus.in_valid = 1'b1;
      tick();
      bus.in_data = 8'hB1;
      #1;
      chk("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
      chk("bp_o1_hold", 32'(bus.o1_data), 32'hB0);
      tick();
      chk("bp_o1_still", 32'(bus.o1_data), 32'hB0);
      bus.o1_ready = 1'b1;
      #1;
      chk("bp_in_ready_high", 32'(bus.in_ready), 32'd1);
      tick();
      bus.in_valid = 1'b0;
      bus.o1_ready = 1'b0;
      #1;
      chk("bp_o1_valid", 32'(bus.o1_valid), 32'd1);
      chk("bp_o1_new", 32'(bus.o1_data), 32'hB1);

      // Independence: o1 stalled and full, o0 still flows
      bus.o0_ready = 1'b1;
      bus.in_data = 8'hA1; bus.in_sel = 1'b0; bus.in_valid = 1'b1;
      #1;
      chk("ind_in_ready", 32'(bus.in_ready), 32'd1);
      tick();
      bus.in_valid = 1'b0;
      #1;
      chk("ind_o0_data", 32'(bus.o0_data), 32'hA1);
      chk("ind_o0_valid", 32'(bus.o0_valid), 32'd1);
      chk("ind_o1_held", 32'(bus.o1_data), 32'hB1);
      chk("ind_o1_valid", 32'(bus.o1_valid), 32'd1);

      // Async reset while o0 holds a stalled beat
      bus.o0_ready = 1'b0;
      bus.in_data = 8'hA2; bus.in_sel = 1'b0; bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      #1;
      chk("ar_o0_full", 32'(bus.o0_valid), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("ar_o0_valid_now", 32'(bus.o0_valid), 32'd0);
      chk("ar_o1_valid_now", 32'(bus.o1_valid), 32'd0);
      chk("ar_o0_data_now", 32'(bus.o0_data), 32'h00);
      tick();
      rst_n = 1'b1;
      bus.o0_ready = 1'b1;
      bus.o1_ready = 1'b1;
      tick();
      chk("ar_no_stale", 32'(bus.o0_valid), 32'd0);
      tick();

`ifdef DEMUX_CNT_EN
      send_beats(1'b0, 3, 8'h10);
      send_beats(1'b1, 2, 8'h20);
      chk("cnt_o0_3", 32'(o0_cnt), 32'd3);
      chk("cnt_o1_2", 32'(o1_cnt), 32'd2);
      send_beats(1'b0, 13, 8'h30);
      chk("cnt_o0_wrap", 32'(o0_cnt), 32'd0);
`else
      send_beats(1'b0, 3, 8'h10);
      send_beats(1'b1, 2, 8'h20);
`endif

      // Random traffic with independent random backpressure
      for (int i = 0; i < 400; i++) begin
         bus.in_valid = ($urandom_range(0, 9) < 7);
         bus.in_sel   = 1'($urandom_range(0, 1));
         bus.in_data  = W'($urandom);
         bus.o0_ready = ($urandom_range(0, 9) < 6);
         bus.o1_ready = ($urandom_range(0, 9) < 6);
         tick();
      end
      bus.in_valid = 1'b0;
      bus.o0_ready = 1'b1;
      bus.o1_ready = 1'b1;
      tick();
      tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
